// File: rtl/timer_pkg.sv
// Shared definitions for the timer bank: register offsets, TCON bit
// positions and the per-channel register selector.
package timer_pkg;

  localparam int unsigned CH_STRIDE      = 16;
  localparam int unsigned CH_IDX_W       = 3;
  localparam logic [7:0]  OFF_TH         = 8'h00;
  localparam logic [7:0]  OFF_TL         = 8'h04;
  localparam logic [7:0]  OFF_TCON       = 8'h08;
  localparam logic [7:0]  OFF_PRESC      = 8'h0C;
  localparam logic [7:0]  OFF_IRQ_STATUS = 8'h80;

  localparam int unsigned TCON_EN      = 0;
  localparam int unsigned TCON_IE      = 1;
  localparam int unsigned TCON_PEND    = 2;
  localparam int unsigned TCON_ONESHOT = 3;

  // Word index within a channel's 16-byte window (addr[3:2]).
  typedef enum logic [1:0] {
    REG_TH    = 2'd0,
    REG_TL    = 2'd1,
    REG_TCON  = 2'd2,
    REG_PRESC = 2'd3
  } reg_sel_e;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: reload/counter/prescaler registers, tick generation
// and overflow handling with set-beats-clear pending priority.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   th_we..presc_we   decoded write strobes for this channel
//   wval, pval, cval  write data sliced for TH/TL, PRESC and TCON
//   pend_clr          IRQ_STATUS write-1-to-clear for this channel
//   th, tl, presc     register values
//   tcon              {ONESHOT, PEND, IE, EN}
//   pend              pending flag
module timer_channel
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               th_we,
  input  logic               tl_we,
  input  logic               tcon_we,
  input  logic               presc_we,
  input  logic [WIDTH-1:0]   wval,
  input  logic [PRESC_W-1:0] pval,
  input  logic [3:0]         cval,
  input  logic               pend_clr,
  output logic [WIDTH-1:0]   th,
  output logic [WIDTH-1:0]   tl,
  output logic [3:0]         tcon,
  output logic [PRESC_W-1:0] presc,
  output logic               pend
);

  logic [PRESC_W-1:0] pcnt;
  logic               en;
  logic               ie;
  logic               oneshot;
  logic               tick;
  logic               ovf;

  // A TL write steals the tick so software sees exactly the value it wrote.
  assign tick = en && !tl_we && (pcnt == presc);
  assign ovf  = tick && (tl == '1);

  always_comb begin
    tcon               = '0;
    tcon[TCON_EN]      = en;
    tcon[TCON_IE]      = ie;
    tcon[TCON_PEND]    = pend;
    tcon[TCON_ONESHOT] = oneshot;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      th      <= '0;
      tl      <= '0;
      presc   <= '0;
      pcnt    <= '0;
      en      <= 1'b0;
      ie      <= 1'b0;
      oneshot <= 1'b0;
      pend    <= 1'b0;
    end else begin
      if (th_we)    th    <= wval;
      if (presc_we) presc <= pval;

      if (tl_we)     tl <= wval;
      else if (ovf)  tl <= th;
      else if (tick) tl <= tl + WIDTH'(1);

      if (!en || tl_we || presc_we || (pcnt == presc)) pcnt <= '0;
      else                                             pcnt <= pcnt + PRESC_W'(1);

      if (tcon_we) begin
        ie      <= cval[TCON_IE];
        oneshot <= cval[TCON_ONESHOT];
      end

      // Software EN write wins over the one-shot auto-disable.
      if (tcon_we)             en <= cval[TCON_EN];
      else if (ovf && oneshot) en <= 1'b0;

      // Overflow set wins over any same-cycle clear so no interrupt is lost.
      if (ovf && ie)                                     pend <= 1'b1;
      else if (pend_clr || (tcon_we && !cval[TCON_PEND])) pend <= 1'b0;
    end
  end

endmodule

// File: rtl/timer_bank.sv
// Bank of NUM_CH memory-mapped up-counting timers with a shared
// write-1-to-clear IRQ_STATUS register and an aggregated interrupt line.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   rd, wr       bus read / write strobes
//   addr, wdata  bus byte address and write data
//   rdata        combinational read data (0 when rd=0 or unmapped)
//   irq_vec      per-channel pending flags
//   irqout       OR of irq_vec
module timer_bank
  import timer_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned PRESC_W   = 8,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd,
  input  logic              wr,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [NUM_CH-1:0] irq_vec,
  output logic              irqout
);

  localparam logic [31:0] CH_SPAN = 32'(NUM_CH * CH_STRIDE);

  logic [31:0]         off;
  logic                ch_hit;
  logic                stat_hit;
  logic [CH_IDX_W-1:0] ch_idx;
  reg_sel_e            rsel;

  logic [WIDTH-1:0]   th_a    [NUM_CH];
  logic [WIDTH-1:0]   tl_a    [NUM_CH];
  logic [3:0]         tcon_a  [NUM_CH];
  logic [PRESC_W-1:0] presc_a [NUM_CH];

  // Unsigned subtraction makes addresses below BASE_ADDR wrap out of range.
  assign off      = addr - BASE_ADDR;
  assign ch_hit   = (off < CH_SPAN) && (off[1:0] == 2'b00);
  assign stat_hit = (off == 32'(OFF_IRQ_STATUS));
  assign ch_idx   = off[6:4];
  assign rsel     = reg_sel_e'(off[3:2]);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic sel;
    assign sel = wr && ch_hit && (ch_idx == CH_IDX_W'(g));

    timer_channel #(
      .WIDTH   (WIDTH),
      .PRESC_W (PRESC_W)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .th_we    (sel && (rsel == REG_TH)),
      .tl_we    (sel && (rsel == REG_TL)),
      .tcon_we  (sel && (rsel == REG_TCON)),
      .presc_we (sel && (rsel == REG_PRESC)),
      .wval     (wdata[WIDTH-1:0]),
      .pval     (wdata[PRESC_W-1:0]),
      .cval     (wdata[3:0]),
      .pend_clr (wr && stat_hit && wdata[g]),
      .th       (th_a[g]),
      .tl       (tl_a[g]),
      .tcon     (tcon_a[g]),
      .presc    (presc_a[g]),
      .pend     (irq_vec[g])
    );
  end

  assign irqout = |irq_vec;

  // Read mux: zero-extended register value, 0 for unmapped or idle bus.
  always_comb begin
    rdata = '0;
    if (rd) begin
      if (stat_hit) begin
        rdata = 32'(irq_vec);
      end else if (ch_hit) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (ch_idx == CH_IDX_W'(i)) begin
            case (rsel)
              REG_TH:    rdata = 32'(th_a[i]);
              REG_TL:    rdata = 32'(tl_a[i]);
              REG_TCON:  rdata = 32'(tcon_a[i]);
              REG_PRESC: rdata = 32'(presc_a[i]);
              default:   rdata = '0;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_timer_bank.sv
// Directed self-checking bench for timer_bank: a default 32-bit instance
// and a 16-bit instance for width/decode checks.
module tb_timer_bank;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd;
  logic        wr_a;
  logic        wr_b;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata_a;
  logic [31:0] rdata_b;
  logic [3:0]  irq_vec_a;
  logic [3:0]  irq_vec_b;
  logic        irqout_a;
  logic        irqout_b;
  logic [31:0] v;

  int n_assert = 0;
  int n_fail   = 0;

  always #10 clk = ~clk;

  timer_bank #(.NUM_CH(4), .WIDTH(32), .PRESC_W(8), .BASE_ADDR(BASE)) dut_a (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr_a), .addr(addr), .wdata(wdata),
    .rdata(rdata_a), .irq_vec(irq_vec_a), .irqout(irqout_a)
  );

  timer_bank #(.NUM_CH(4), .WIDTH(16), .PRESC_W(8), .BASE_ADDR(BASE)) dut_b (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr_b), .addr(addr), .wdata(wdata),
    .rdata(rdata_b), .irq_vec(irq_vec_b), .irqout(irqout_b)
  );

  function automatic logic [31:0] ra(input int ch, input int off);
    return BASE + 32'(16 * ch + off);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance n clocks, landing just after a falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // One-cycle bus write; the write lands on the next rising edge.
  task automatic bus_wr(input bit sel_b, input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    if (sel_b) wr_b = 1'b1;
    else       wr_a = 1'b1;
    @(negedge clk);
    #1;
    wr_a = 1'b0;
    wr_b = 1'b0;
  endtask

  task automatic bus_rd(input bit sel_b, input logic [31:0] a, output logic [31:0] d);
    addr = a;
    rd   = 1'b1;
    #1;
    d  = sel_b ? rdata_b : rdata_a;
    rd = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rd = 1'b0; wr_a = 1'b0; wr_b = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;

    // Reset values
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        bus_rd(1'b0, ra(c, 4 * r), v);
        check($sformatf("reset_ch%0d_r%0d", c, r), v, 32'h0);
      end
      step(1);
    end
    bus_rd(1'b0, BASE + 32'h80, v); check("reset_status", v, 32'h0);
    check("reset_irqout_a", 32'(irqout_a), 32'h0);
    check("reset_irqvec_a", 32'(irq_vec_a), 32'h0);
    check("reset_irqout_b", 32'(irqout_b), 32'h0);

    // Decode: misaligned / unmapped reads return 0, writes ignored
    bus_rd(1'b0, BASE + 32'h2, v);  check("rd_misaligned", v, 32'h0);
    bus_rd(1'b0, BASE + 32'h84, v); check("rd_unmapped84", v, 32'h0);
    bus_rd(1'b0, BASE + 32'h40, v); check("rd_unmapped40", v, 32'h0);
    bus_wr(1'b0, BASE + 32'h2, 32'hFFFF_FFFF);
    bus_wr(1'b0, BASE + 32'h84, 32'hFFFF_FFFF);
    bus_wr(1'b0, BASE + 32'h1, 32'h0000_000B);
    bus_rd(1'b0, ra(0, 0), v); check("wr_ignored_th0", v, 32'h0);
    bus_rd(1'b0, ra(0, 8), v); check("wr_ignored_tcon0", v, 32'h0);

    // Width 16: write data truncated, reads zero-extended
    bus_wr(1'b1, ra(0, 0), 32'hABCD_1234);
    bus_wr(1'b1, ra(1, 4), 32'hFFFF_FFFF);
    bus_wr(1'b1, ra(0, 12), 32'h0000_01FF);
    bus_rd(1'b1, ra(0, 0), v);  check("w16_th", v, 32'h0000_1234);
    bus_rd(1'b1, ra(1, 4), v);  check("w16_tl", v, 32'h0000_FFFF);
    bus_rd(1'b1, ra(0, 12), v); check("w16_presc", v, 32'h0000_00FF);
    bus_rd(1'b1, BASE + 32'h2, v); check("w16_misaligned", v, 32'h0);

    // Periodic overflow on ch0, 4-cycle period
    bus_wr(1'b0, ra(0, 0), 32'hFFFF_FFFC);
    bus_wr(1'b0, ra(0, 4), 32'hFFFF_FFFC);
    bus_wr(1'b0, ra(0, 12), 32'h0);
    bus_wr(1'b0, ra(0, 8), 32'h3);
    bus_rd(1'b0, ra(0, 4), v); check("p_tl_start", v, 32'hFFFF_FFFC);
    step(3);
    bus_rd(1'b0, ra(0, 4), v); check("p_tl_ff", v, 32'hFFFF_FFFF);
    check("p_irq_before", 32'(irqout_a), 32'h0);
    step(1);
    bus_rd(1'b0, ra(0, 4), v); check("p_tl_wrap1", v, 32'hFFFF_FFFC);
    check("p_irqout", 32'(irqout_a), 32'h1);
    check("p_irqvec", 32'(irq_vec_a), 32'h1);
    bus_rd(1'b0, BASE + 32'h80, v); check("p_status", v, 32'h1);
    step(4);
    bus_rd(1'b0, ra(0, 4), v); check("p_tl_wrap2", v, 32'hFFFF_FFFC);
    bus_wr(1'b0, ra(0, 8), 32'h0);
    check("p_tcon_clr_irq", 32'(irqout_a), 32'h0);

    // Prescaler + one-shot on ch2
    bus_wr(1'b0, ra(2, 4), 32'hFFFF_FFFE);
    bus_wr(1'b0, ra(2, 0), 32'h5);
    bus_wr(1'b0, ra(2, 12), 32'h3);
    bus_wr(1'b0, ra(2, 8), 32'hB);
    step(3);
    bus_rd(1'b0, ra(2, 4), v); check("os_tl_hold", v, 32'hFFFF_FFFE);
    step(1);
    bus_rd(1'b0, ra(2, 4), v); check("os_tl_ff", v, 32'hFFFF_FFFF);
    step(4);
    bus_rd(1'b0, ra(2, 4), v); check("os_tl_reload", v, 32'h5);
    bus_rd(1'b0, ra(2, 8), v); check("os_tcon", v, 32'hE);
    check("os_irqvec", 32'(irq_vec_a), 32'h4);
    step(8);
    bus_rd(1'b0, ra(2, 4), v); check("os_tl_frozen", v, 32'h5);
    bus_wr(1'b0, BASE + 32'h80, 32'h4);
    check("os_status_clr", 32'(irqout_a), 32'h0);

    // Clear/set race on ch1
    bus_wr(1'b0, ra(1, 0), 32'hFFFF_FFF0);
    bus_wr(1'b0, ra(1, 4), 32'hFFFF_FFFD);
    bus_wr(1'b0, ra(1, 12), 32'h0);
    bus_wr(1'b0, ra(1, 8), 32'h3);
    step(2);
    bus_rd(1'b0, ra(1, 4), v); check("race_tl_ff", v, 32'hFFFF_FFFF);
    bus_wr(1'b0, BASE + 32'h80, 32'h2);
    check("race_set_wins", 32'(irq_vec_a), 32'h2);
    bus_wr(1'b0, ra(1, 8), 32'h6);
    check("race_tcon_pend1_noop", 32'(irqout_a), 32'h1);
    bus_wr(1'b0, BASE + 32'h80, 32'h2);
    check("race_clear_later", 32'(irqout_a), 32'h0);

    // Write-vs-tick and IE gating on ch3
    bus_wr(1'b0, ra(3, 0), 32'h100);
    bus_wr(1'b0, ra(3, 4), 32'hFFFF_FFFF);
    bus_wr(1'b0, ra(3, 12), 32'h0);
    bus_wr(1'b0, ra(3, 8), 32'h3);
    bus_wr(1'b0, ra(3, 4), 32'h7);
    bus_rd(1'b0, ra(3, 4), v); check("wt_tl_written", v, 32'h7);
    check("wt_no_pend", 32'(irq_vec_a), 32'h0);
    step(1);
    bus_rd(1'b0, ra(3, 4), v); check("wt_tl_inc", v, 32'h8);
    bus_wr(1'b0, ra(3, 8), 32'h1);
    bus_wr(1'b0, ra(3, 4), 32'hFFFF_FFFE);
    step(2);
    bus_rd(1'b0, ra(3, 4), v); check("ie0_reload", v, 32'h100);
    check("ie0_no_pend", 32'(irq_vec_a), 32'h0);
    bus_wr(1'b0, ra(3, 8), 32'h2);
    step(2);
    check("ie_late_no_irq", 32'(irqout_a), 32'h0);

    // Reset mid-count
    bus_wr(1'b0, ra(0, 8), 32'h3);
    step(3);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    bus_rd(1'b0, ra(0, 4), v); check("rst_mid_tl", v, 32'h0);
    bus_rd(1'b0, ra(0, 8), v); check("rst_mid_tcon", v, 32'h0);
    check("rst_mid_irq", 32'(irqout_a), 32'h0);
    step(4);
    check("rst_mid_irq_later", 32'(irqout_a), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_bank.md
Name: timer_bank

Overview:
- Parametrised successor to the single-timer memory-mapped peripheral.
- Provides NUM_CH independent up-counting timers on the CPU load/store bus, each with a reload value, prescaler, periodic/one-shot mode and interrupt enable.
- Per-channel interrupts are aggregated into a central write-1-to-clear status register.
- Drives the CPU irq line.

Parameters:
- NUM_CH, 4, number of timer channels (1..8)
- WIDTH, 32, counter/reload width in bits (8..32)
- PRESC_W, 8, prescaler register width in bits (1..16)
- BASE_ADDR, 32'h40000000, byte address of channel 0 TH

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rd  in  1  bus read strobe
- wr  in  1  bus write strobe
- addr  in  32  bus byte address
- wdata  in  32  bus write data
- rdata  out  32  bus read data (combinational)
- irq_vec  out  NUM_CH  per-channel pending flags
- irqout  out  1  OR of irq_vec

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, port name reset.
  - On reset, all TH, TL, TCON, PRESC, prescaler counters and pending bits are 0.
  - Therefore irq_vec = 0 and irqout = 0.
  - Reset mid-count aborts immediately; no overflow is reported.
- Channel register map (channel n base = BASE_ADDR + 16*n):
  - +0x0 TH: reload value, WIDTH bits.
  - +0x4 TL: live counter, WIDTH bits.
  - +0x8 TCON: [0] EN, [1] IE, [2] PEND (read), [3] ONESHOT.
  - +0xC PRESC: PRESC_W bits.
- Global register: BASE_ADDR+0x80 IRQ_STATUS. Read returns pending bits zero-extended. Write: each 1 bit clears that channel's PEND.
- Address decode:
  - Full 32-bit compare; misaligned or unmapped addresses read 0 and ignore writes.
  - Writes take wdata[WIDTH-1:0] (or [PRESC_W-1:0]).
  - Reads are zero-extended.
- rdata: combinational. The addressed value when rd=1, else 0. Reads have no side effects.
- Prescaler and tick:
  - While EN=1, the prescaler counter increments each cycle.
  - When it equals PRESC, it returns to 0 and a tick occurs, so PRESC=0 gives a tick every cycle and PRESC=k gives a tick every k+1 cycles.
  - While EN=0, the prescaler counter is held at 0 and TL is frozen.
- Count and overflow: on a tick, if TL != all-ones, TL <= TL+1. Otherwise an overflow occurs:
  - TL <= TH.
  - If IE=1, PEND <= 1.
  - If ONESHOT=1, EN <= 0.
  - Overflow period with PRESC=0 is (2^WIDTH - TH) cycles.
- Write to TL or TH: write data is registered next edge.
  - A bus write to a channel's TL suppresses that channel's tick in the same cycle: no increment, no overflow, and the prescaler counter resets to 0.
  - A write to PRESC also resets the prescaler counter.
- Write to TCON:
  - Bits [0], [1] and [3] take wdata.
  - Writing 0 to bit 2 clears PEND; writing 1 to bit 2 has no effect.
- Simultaneous events:
  - An overflow PEND-set beats any same-cycle PEND clear (TCON or IRQ_STATUS), so no interrupt is lost.
  - A TCON write of EN beats a same-cycle one-shot EN clear.
  - IE=0 at overflow means PEND is not set. Enabling IE later does not raise a stale interrupt.
- Outputs:
  - irq_vec[n] = PEND of channel n, registered.
  - irqout = |irq_vec, so it is valid in the cycle after the overflow edge.

Decomposition:
- Shared package (timer_pkg):
  - Register offsets (OFF_TH=0, OFF_TL=4, OFF_TCON=8, OFF_PRESC=12, OFF_IRQ_STATUS=8'h80, CH_STRIDE=16).
  - TCON bit indices (EN=0, IE=1, PEND=2, ONESHOT=3).
- Sub-module timer_channel (parameters WIDTH, PRESC_W) holds one channel's registers, prescaler and overflow/priority logic.
  - Inputs: decoded write strobes, wdata, pend_clr.
  - Outputs: TH, TL, TCON and PRESC values, plus pend.
- timer_bank instantiates NUM_CH channels with a generate loop and owns address decode, the read mux and IRQ aggregation.

Test Plan:
- Reset values: assert reset 2 cycles, then read every register -> all 0; irqout=0.
- Periodic overflow: ch0 TH=32'hFFFFFFFC, TL=32'hFFFFFFFC, PRESC=0, TCON=4'b0011 -> TL wraps to 32'hFFFFFFFC every 4 cycles; irqout=1 from the cycle after the first wrap; IRQ_STATUS reads 32'h1.
- Prescaler and one-shot: ch2 TL=32'hFFFFFFFE, TH=5, PRESC=3, TCON=4'b1011 -> TL=FFFFFFFF after 4 cycles, 5 after 8 cycles; then EN=0 and TL stays 5; TCON reads 4'b1110; irq_vec=4'b0100.
- Clear/set race: ch1 overflows in the same cycle software writes 32'h2 to IRQ_STATUS -> PEND stays 1; a write of 32'h2 on a later cycle clears it and irqout falls the next cycle.
- Write-vs-tick and IE gating: writing TL=7 in a would-be overflow cycle -> TL=7, no reload, no PEND. Overflow with IE=0 -> PEND=0; setting IE afterwards -> irqout stays 0.
- Decode and width: with WIDTH=16, writing 32'hABCD1234 to TH reads back 32'h00001234. A read of BASE_ADDR+0x2 or BASE_ADDR+0x84 returns 0, and writes there change nothing.
